// File: rtl/decode_regfile_pkg.sv
// Shared sizing for the decode-side register file and its scoreboard.
package decode_regfile_pkg;
    localparam int DR_XLEN = 32;   // default register / writeback data width
    localparam int NREG    = 32;   // architectural registers, x0 hardwired to zero
    localparam int REG_W   = 5;    // register index width

    typedef logic [REG_W-1:0] reg_idx_t;

    // True when a write this cycle targets a real (non-x0) register idx.
    function automatic logic wr_hits(input logic wr, input reg_idx_t wr_idx,
                                     input reg_idx_t idx);
        return wr && (wr_idx == idx) && (idx != '0);
    endfunction
endpackage

// File: rtl/decode_regfile_if.sv
// Writeback + decode request/response bundle seen by the register file.
interface decode_regfile_if
    import decode_regfile_pkg::*;
#(
    parameter int XLEN = DR_XLEN
);
    logic            i_rf_wr;
    reg_idx_t        i_rf_rd;
    logic [XLEN-1:0] i_rf_data;
    logic            i_req;
    reg_idx_t        i_rs1;
    reg_idx_t        i_rs2;
    logic            i_dst_vld;
    reg_idx_t        i_dst;
    logic            i_flush;
    logic            o_hazard;
    logic [XLEN-1:0] o_rs1_data;
    logic [XLEN-1:0] o_rs2_data;
    logic            o_rd_vld;
    logic [NREG-1:0] o_busy;

    // Pipeline side: drives writes and decode requests.
    modport master (
        output i_rf_wr, i_rf_rd, i_rf_data, i_req, i_rs1, i_rs2,
               i_dst_vld, i_dst, i_flush,
        input  o_hazard, o_rs1_data, o_rs2_data, o_rd_vld, o_busy
    );

    // Register file side.
    modport slave (
        input  i_rf_wr, i_rf_rd, i_rf_data, i_req, i_rs1, i_rs2,
               i_dst_vld, i_dst, i_flush,
        output o_hazard, o_rs1_data, o_rs2_data, o_rd_vld, o_busy
    );
endinterface

// File: rtl/decode_regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register marks an outstanding producer.
module reg_scoreboard
    import decode_regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  reg_idx_t        set_idx,
    input  logic            clr_en,
    input  reg_idx_t        clr_idx,
    input  logic            flush,
    input  reg_idx_t        rs1,
    input  reg_idx_t        rs2,
    output logic [NREG-1:0] busy,
    output logic            busy1,
    output logic            busy2
);
    logic [NREG-1:0] busy_nxt;

    // Next scoreboard: clear first so a same-index set (new producer) wins;
    // flush discards everything; x0 never becomes busy.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_idx] = 1'b0;
        if (set_en) busy_nxt[set_idx] = 1'b1;
        if (flush)  busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    assign busy1 = busy[rs1];
    assign busy2 = busy[rs2];
endmodule

// File: rtl/decode_regfile.sv
// Decode-side register file: 1 write port, 2 registered read ports with
// same-cycle write bypass, and a hazard stall driven by the scoreboard.
module decode_regfile
    import decode_regfile_pkg::*;
#(
    parameter int XLEN = DR_XLEN
)(
    input logic              clk,
    input logic              rst_n,
    decode_regfile_if.slave  bus
);
    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] rd1, rd2;
    logic            busy1, busy2, clr1, clr2, accept, set_en, clr_en;

    // A write landing this cycle resolves the hazard because bypass supplies it.
    assign clr1   = bus.i_rf_wr && (bus.i_rf_rd == bus.i_rs1);
    assign clr2   = bus.i_rf_wr && (bus.i_rf_rd == bus.i_rs2);
    assign bus.o_hazard = bus.i_req &&
                          ((busy1 && bus.i_rs1 != '0 && !clr1) ||
                           (busy2 && bus.i_rs2 != '0 && !clr2));
    assign accept = bus.i_req && !bus.o_hazard && !bus.i_flush;
    assign set_en = accept && bus.i_dst_vld && (bus.i_dst != '0);
    assign clr_en = bus.i_rf_wr && (bus.i_rf_rd != '0);

    reg_scoreboard u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (set_en),
        .set_idx (bus.i_dst),
        .clr_en  (clr_en),
        .clr_idx (bus.i_rf_rd),
        .flush   (bus.i_flush),
        .rs1     (bus.i_rs1),
        .rs2     (bus.i_rs2),
        .busy    (bus.o_busy),
        .busy1   (busy1),
        .busy2   (busy2)
    );

    // Operand select: x0 reads zero, an in-flight write beats array content.
    always_comb begin
        rd1 = regs[bus.i_rs1];
        rd2 = regs[bus.i_rs2];
        if (wr_hits(bus.i_rf_wr, bus.i_rf_rd, bus.i_rs1)) rd1 = bus.i_rf_data;
        if (wr_hits(bus.i_rf_wr, bus.i_rf_rd, bus.i_rs2)) rd2 = bus.i_rf_data;
        if (bus.i_rs1 == '0) rd1 = '0;
        if (bus.i_rs2 == '0) rd2 = '0;
    end

    // Register array write; x0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (clr_en) begin
            regs[bus.i_rf_rd] <= bus.i_rf_data;
        end
    end

    // Operand output registers: capture on accept, otherwise hold data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_rs1_data <= '0;
            bus.o_rs2_data <= '0;
            bus.o_rd_vld   <= 1'b0;
        end else begin
            bus.o_rd_vld <= accept;
            if (accept) begin
                bus.o_rs1_data <= rd1;
                bus.o_rs2_data <= rd2;
            end
        end
    end
endmodule

// File: tb/tb_decode_regfile.sv
// Bench for decode_regfile: directed vector table, a reset corner sequence,
// then random traffic against a behavioural register-file model.
module tb_decode_regfile;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    decode_regfile_if #(.XLEN(32)) bus ();
    decode_regfile #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        req;
        logic [4:0]  rs1, rs2;
        logic        dv;
        logic [4:0]  dst;
        logic        fl;
        logic        haz;
        logic        vld;
        logic [31:0] e1, e2, ebusy;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state
    logic [31:0] mregs [32];
    logic [31:0] mbusy;
    logic [31:0] m1, m2;
    logic        mvld;

    function automatic vec_t mk(logic wr, logic [4:0] rd, logic [31:0] wdata,
                                logic req, logic [4:0] rs1, logic [4:0] rs2,
                                logic dv, logic [4:0] dst, logic fl,
                                logic haz, logic vld, logic [31:0] e1,
                                logic [31:0] e2, logic [31:0] ebusy);
        vec_t v;
        v.wr = wr; v.rd = rd; v.wdata = wdata; v.req = req; v.rs1 = rs1;
        v.rs2 = rs2; v.dv = dv; v.dst = dst; v.fl = fl; v.haz = haz;
        v.vld = vld; v.e1 = e1; v.e2 = e2; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.i_rf_wr = v.wr;   bus.i_rf_rd = v.rd;   bus.i_rf_data = v.wdata;
        bus.i_req   = v.req;  bus.i_rs1   = v.rs1;  bus.i_rs2     = v.rs2;
        bus.i_dst_vld = v.dv; bus.i_dst   = v.dst;  bus.i_flush   = v.fl;
    endtask

    // Directed row: hazard before the edge, outputs after it.
    task automatic tstep(input int n, input vec_t v);
        drive(v);
        #1;
        chk($sformatf("row%0d hazard", n), 32'(bus.o_hazard), 32'(v.haz));
        @(posedge clk); #1;
        chk($sformatf("row%0d rd_vld", n), 32'(bus.o_rd_vld), 32'(v.vld));
        chk($sformatf("row%0d rs1", n), bus.o_rs1_data, v.e1);
        chk($sformatf("row%0d rs2", n), bus.o_rs2_data, v.e2);
        chk($sformatf("row%0d busy", n), bus.o_busy, v.ebusy);
        @(negedge clk);
    endtask

    function automatic logic [31:0] mread(logic [4:0] r, vec_t v);
        if (r == 0) return 32'h0;
        if (v.wr && v.rd == r) return v.wdata;
        return mregs[r];
    endfunction

    task automatic mreset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mbusy = 32'h0; m1 = 32'h0; m2 = 32'h0; mvld = 1'b0;
    endtask

    // Model-checked cycle.
    task automatic rstep(input string tag, input vec_t v);
        logic haz, acc;
        drive(v);
        haz = v.req && ((v.rs1 != 0 && mbusy[v.rs1] && !(v.wr && v.rd == v.rs1)) ||
                        (v.rs2 != 0 && mbusy[v.rs2] && !(v.wr && v.rd == v.rs2)));
        acc = v.req && !haz && !v.fl;
        #1;
        chk({tag, " hazard"}, 32'(bus.o_hazard), 32'(haz));
        if (acc) begin
            m1 = mread(v.rs1, v);
            m2 = mread(v.rs2, v);
        end
        mvld = acc;
        if (v.wr && v.rd != 0) mregs[v.rd] = v.wdata;
        if (v.fl) mbusy = 32'h0;
        else begin
            if (v.wr && v.rd != 0) mbusy[v.rd] = 1'b0;
            if (acc && v.dv && v.dst != 0) mbusy[v.dst] = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, " rd_vld"}, 32'(bus.o_rd_vld), 32'(mvld));
        chk({tag, " rs1"}, bus.o_rs1_data, m1);
        chk({tag, " rs2"}, bus.o_rs2_data, m2);
        chk({tag, " busy"}, bus.o_busy, mbusy);
        @(negedge clk);
    endtask

    initial begin
        vec_t idle, v;
        idle = mk(0,0,0, 0,0,0, 0,0, 0, 0,0,0,0,0);
        drive(idle);
        mreset();

        // Vectors from reset; data outputs hold when rd_vld is low.
        tbl.push_back(mk(1,5,32'hDEADBEEF, 0,0,0, 0,0, 0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0, 1,5,0, 0,0, 0, 0,1,32'hDEADBEEF,0,0));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0, 0,0,32'hDEADBEEF,0,0));
        tbl.push_back(mk(1,7,32'h12345678, 1,7,5, 0,0, 0, 0,1,32'h12345678,32'hDEADBEEF,0));
        tbl.push_back(mk(1,0,32'hFFFFFFFF, 0,0,0, 0,0, 0, 0,0,32'h12345678,32'hDEADBEEF,0));
        tbl.push_back(mk(0,0,0, 1,0,0, 0,0, 0, 0,1,0,0,0));
        tbl.push_back(mk(0,0,0, 1,0,0, 1,9, 0, 0,1,0,0,32'h200));
        tbl.push_back(mk(0,0,0, 1,5,9, 0,0, 0, 1,0,0,0,32'h200));
        tbl.push_back(mk(1,9,32'hA5, 1,5,9, 0,0, 0, 0,1,32'hDEADBEEF,32'hA5,0));
        tbl.push_back(mk(1,3,32'h11, 1,0,0, 1,3, 0, 0,1,0,0,32'h8));
        tbl.push_back(mk(0,0,0, 1,0,0, 1,4, 0, 0,1,0,0,32'h18));
        tbl.push_back(mk(0,0,0, 1,0,0, 1,9, 0, 0,1,0,0,32'h218));
        tbl.push_back(mk(1,4,32'h55, 1,1,2, 1,6, 1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0, 1,4,3, 0,0, 0, 0,1,32'h55,32'h11,0));
        tbl.push_back(mk(0,0,0, 1,4,3, 1,4, 0, 0,1,32'h55,32'h11,32'h10));
        tbl.push_back(mk(0,0,0, 1,4,0, 0,0, 0, 1,0,32'h55,32'h11,32'h10));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 1, 0,0,32'h55,32'h11,0));

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        foreach (tbl[i]) tstep(i, tbl[i]);

        // Asynchronous reset in the middle of a request.
        tstep(100, mk(0,0,0, 1,4,0, 1,9, 0, 0,1,32'h55,0,32'h200));
        drive(mk(0,0,0, 1,5,0, 0,0, 0, 0,0,0,0,0));
        #2 rst_n = 1'b0;
        #1;
        chk("async rd_vld", 32'(bus.o_rd_vld), 0);
        chk("async rs1", bus.o_rs1_data, 0);
        chk("async busy", bus.o_busy, 0);
        drive(idle);
        @(posedge clk); #1;
        chk("reset held rd_vld", 32'(bus.o_rd_vld), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mreset();
        rstep("post-reset x5", mk(0,0,0, 1,5,0, 0,0, 0, 0,0,0,0,0));

        // Random traffic over a small register window so hazards are common.
        for (int n = 0; n < 400; n++) begin
            v = idle;
            v.wr    = ($urandom_range(0, 1) == 0);
            v.rd    = 5'($urandom_range(0, 7));
            v.wdata = $urandom;
            v.req   = ($urandom_range(0, 9) < 7);
            v.rs1   = 5'($urandom_range(0, 7));
            v.rs2   = 5'($urandom_range(0, 7));
            v.dv    = ($urandom_range(0, 1) == 0);
            v.dst   = 5'($urandom_range(0, 7));
            v.fl    = ($urandom_range(0, 19) == 0);
            rstep($sformatf("rand%0d", n), v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_regfile.md
Name: decode_regfile

Overview:
- Decode-side sink of the writeback interface: a 32 x `N register file plus a busy-bit scoreboard.
- Accepts one write per cycle from the Writeback stage.
- Serves two registered operand reads per accepted decode request, with same-cycle write bypass.
- Raises a hazard stall when a requested source register has an outstanding producer.

Parameters:
XLEN, `N, data width of registers and the write port.
NREG, 32, number of architectural registers; index 0 is hardwired to zero.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_rf_wr  input  1  writeback write enable
i_rf_rd  input  5  writeback destination register
i_rf_data  input  XLEN  writeback data
i_req  input  1  decode requests an operand read this cycle
i_rs1  input  5  source register 1 address
i_rs2  input  5  source register 2 address
i_dst_vld  input  1  requesting instruction writes a destination
i_dst  input  5  destination of the requesting instruction
i_flush  input  1  pipeline flush; clears scoreboard and read valid
o_hazard  output  1  request blocked: source operand busy (combinational)
o_rs1_data  output  XLEN  registered rs1 operand
o_rs2_data  output  XLEN  registered rs2 operand
o_rd_vld  output  1  operands valid, one-cycle pulse per accepted request
o_busy  output  NREG  scoreboard vector, for debug and verification

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous, active-low (clk, rst_n).
- Reset values: all registers = 0, busy = 0, o_rs1_data = o_rs2_data = 0, o_rd_vld = 0. Reset mid-request discards the request; first valid read comes from a fresh i_req after deassertion.
- Write:
  - On posedge clk, if i_rf_wr && i_rf_rd != 0, then regs[i_rf_rd] <= i_rf_data.
  - Writes to x0 are ignored; reads of x0 always return 0.
- Accept: accept = i_req && !o_hazard && !i_flush.
- Read latency:
  - 1 cycle. On an accepted request, o_rsN_data <= value of rsN at that edge, and o_rd_vld <= 1.
  - Otherwise o_rd_vld <= 0 and the data outputs hold their last value.
- Bypass: if i_rf_wr && i_rf_rd == rsN && rsN != 0 in the accept cycle, o_rsN_data <= i_rf_data (the write wins over stale array content).
- Hazard:
  - o_hazard = i_req && ((busy[rs1] && rs1 != 0 && !clr1) || (busy[rs2] && rs2 != 0 && !clr2)).
  - clrN = i_rf_wr && i_rf_rd == rsN, i.e. a write arriving this cycle resolves the hazard via bypass.
- Scoreboard update, per edge:
  - set busy[i_dst] on accept && i_dst_vld && i_dst != 0.
  - clear busy[i_rf_rd] on i_rf_wr && i_rf_rd != 0.
  - set and clear to the same index in the same cycle: set wins (the new producer is outstanding).
- Self-dependency (rs == dst of the same request): the hazard is evaluated against the pre-update busy, so the request is accepted and reads the old value.
- i_flush:
  - busy <= 0 and o_rd_vld <= 0 at the next edge; flush overrides set.
  - Register writes in the same cycle still commit.
- busy[0] is constant 0.
- Writes are never back-pressured; the writeback side has no ready signal.

Decomposition:
- Shared defines header (existing): `N, opcode constants, register-index width (5), NREG.
- One natural sub-module, reg_scoreboard:
  - inputs: set_en, set_idx, clr_en, clr_idx, flush, rs1, rs2.
  - outputs: busy vector, busy1, busy2.
- The top level holds the register array, the bypass muxes and the output registers.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle → o_rd_vld, data outputs and o_busy go to 0 immediately without a clock edge; a read of x5 after release returns 0.
2. Write then read: write x5=0xDEADBEEF; next cycle i_req rs1=5, rs2=0 → one cycle later o_rs1_data=0xDEADBEEF, o_rs2_data=0, o_rd_vld=1 for exactly one cycle.
3. Bypass: same cycle write x7=0x12345678 and i_req rs1=7 → o_rs1_data=0x12345678 next cycle; a write to x0 with data 0xFFFFFFFF followed by a read of rs1=0 → 0.
4. Scoreboard stall:
   - Accept i_dst_vld=1, i_dst=9; next cycle request rs2=9 → o_hazard=1, no o_rd_vld.
   - Write x9=0xA5 → o_hazard=0 in that cycle; operand=0xA5; busy[9] cleared.
5. Set/clear collision: same cycle i_rf_wr to x3 and an accepted request with i_dst=3 → busy[3]=1 afterwards.
6. Flush: busy = {x4, x9} set and i_flush=1 with i_req → o_busy=0, o_rd_vld=0 next cycle; a concurrent write to x4=0x55 still lands (a later read returns 0x55).
